// File: rtl/unidade_controle_rodadas.sv
// Round/address/timeout control unit for the sequence-memory game.
// Moore FSM; outputs decode only from state and registered counters.
module unidade_controle_rodadas #(
    parameter int ADDR_W    = 4,
    parameter int N_RODADAS = 16,
    parameter int TIMEOUT   = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              jogada,
    input  logic              igual,
    input  logic              timeout_en,
    output logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] rodada,
    output logic              zeraR,
    output logic              registraR,
    output logic              pronto,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic [3:0]        db_estado
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]     TIMER_MAX = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ULTIMA    = ADDR_W'(N_RODADAS - 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        INICIALIZA     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        PROXIMA        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FINAL_ACERTO   = 4'h8,
        FINAL_ERRO     = 4'h9,
        FINAL_TIMEOUT  = 4'hA
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] rodada_q, rodada_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              expirou;

    assign expirou = (timer_q == TIMER_MAX);

    // State and counter registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            endereco_q <= '0;
            rodada_q   <= '0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            rodada_q   <= rodada_d;
            timer_q    <= timer_d;
        end
    end

    // Next-state logic; unused codes fall back to inicial
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:        if (iniciar) estado_d = INICIALIZA;
            INICIALIZA:     estado_d = INICIO_RODADA;
            INICIO_RODADA:  estado_d = ESPERA;
            ESPERA: begin
                if (jogada)
                    estado_d = REGISTRA;
                else if (timeout_en && expirou)
                    estado_d = FINAL_TIMEOUT;
            end
            REGISTRA:       estado_d = COMPARA;
            COMPARA: begin
                if (!igual)
                    estado_d = FINAL_ERRO;
                else if (endereco_q != rodada_q)
                    estado_d = PROXIMA;
                else if (rodada_q == ULTIMA)
                    estado_d = FINAL_ACERTO;
                else
                    estado_d = PROXIMA_RODADA;
            end
            PROXIMA:        estado_d = ESPERA;
            PROXIMA_RODADA: estado_d = INICIO_RODADA;
            FINAL_ACERTO,
            FINAL_ERRO,
            FINAL_TIMEOUT:  if (iniciar) estado_d = INICIALIZA;
            default:        estado_d = INICIAL;
        endcase
    end

    // Address, round and move-timer updates; counters hold in final states
    always_comb begin
        endereco_d = endereco_q;
        rodada_d   = rodada_q;
        timer_d    = '0;
        case (estado_q)
            INICIAL, INICIALIZA: begin
                endereco_d = '0;
                rodada_d   = '0;
            end
            INICIO_RODADA:  endereco_d = '0;
            PROXIMA:        endereco_d = endereco_q + 1'b1;
            PROXIMA_RODADA: rodada_d   = rodada_q + 1'b1;
            ESPERA: begin
                if (jogada || expirou)
                    timer_d = timer_q;
                else
                    timer_d = timer_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Moore output decode
    always_comb begin
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = estado_q;
        case (estado_q)
            INICIAL, INICIALIZA: zeraR = 1'b1;
            REGISTRA:            registraR = 1'b1;
            FINAL_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FINAL_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FINAL_TIMEOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                timeout = 1'b1;
            end
            INICIO_RODADA, ESPERA, COMPARA,
            PROXIMA, PROXIMA_RODADA: ;
            default: db_estado = 4'hF;
        endcase
    end

    assign endereco = endereco_q;
    assign rodada   = rodada_q;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Randomized game-level bench for unidade_controle_rodadas.
// Expected outcomes come from the game rules, not from the FSM structure.
module tb_unidade_controle_rodadas;

    localparam int AW = 4;
    localparam int NR = 4;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset, iniciar, jogada, igual, timeout_en;
    logic [AW-1:0] endereco, rodada;
    logic          zeraR, registraR, pronto, acertou, errou, timeout;
    logic [3:0]    db_estado;

    int checks = 0;
    int errors = 0;

    unidade_controle_rodadas #(
        .ADDR_W(AW), .N_RODADAS(NR), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada(jogada), .igual(igual), .timeout_en(timeout_en),
        .endereco(endereco), .rodada(rodada), .zeraR(zeraR),
        .registraR(registraR), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] code, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (db_estado == code) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        checks++;
        if (db_estado !== 4'h1 || zeraR !== 1'b1) begin
            errors++;
            $display("FAIL start: db=%h zeraR=%b want db=1 zeraR=1",
                     db_estado, zeraR);
        end
    endtask

    // One move: pulse, registra, compara, then land on the result state
    task automatic do_move(input logic v);
        jogada = 1'b1;
        igual  = v;
        tick();
        jogada = 1'b0;
        checks++;
        if (db_estado !== 4'h4 || registraR !== 1'b1) begin
            errors++;
            $display("FAIL registra: db=%h regR=%b want db=4 regR=1",
                     db_estado, registraR);
        end
        tick();
        tick();
        igual = 1'b0;
    endtask

    // kind 0 = win, 1 = wrong move at (fr,fm), 2 = timeout at (fr,fm)
    task automatic play_game(input int kind, input int fr, input int fm);
        bit   ok;
        bit   stop;
        int   cnt;
        int   gap;
        logic [3:0]    exp_db;
        logic [AW-1:0] exp_r, exp_e;
        stop = 1'b0;
        timeout_en = 1'b1;
        start_game();
        for (int r = 0; r < NR && !stop; r++) begin
            for (int m = 0; m <= r && !stop; m++) begin
                wait_state(4'h3, ok);
                checks++;
                if (!ok || endereco !== AW'(m) || rodada !== AW'(r)) begin
                    errors++;
                    $display("FAIL espera: ok=%b e=%0d r=%0d want e=%0d r=%0d",
                             ok, endereco, rodada, m, r);
                end
                if (kind == 1 && r == fr && m == fm) begin
                    do_move(1'b0);
                    stop = 1'b1;
                end else if (kind == 2 && r == fr && m == fm) begin
                    cnt = 0;
                    while (db_estado == 4'h3 && cnt < 50) begin
                        cnt++;
                        tick();
                    end
                    checks++;
                    if (cnt != TO) begin
                        errors++;
                        $display("FAIL espera_len: got %0d want %0d", cnt, TO);
                    end
                    stop = 1'b1;
                end else begin
                    gap = $urandom_range(0, TO - 1);
                    repeat (gap) tick();
                    do_move(1'b1);
                end
            end
        end
        exp_db = (kind == 0) ? 4'h8 : (kind == 1) ? 4'h9 : 4'hA;
        exp_r  = (kind == 0) ? AW'(NR - 1) : AW'(fr);
        exp_e  = (kind == 0) ? AW'(NR - 1) : AW'(fm);
        checks++;
        if (db_estado !== exp_db || rodada !== exp_r || endereco !== exp_e) begin
            errors++;
            $display("FAIL final_pos: db=%h r=%0d e=%0d want db=%h r=%0d e=%0d",
                     db_estado, rodada, endereco, exp_db, exp_r, exp_e);
        end
        checks++;
        if (pronto !== 1'b1 || acertou !== (kind == 0) ||
            errou !== (kind != 0) || timeout !== (kind == 2) ||
            zeraR !== 1'b0) begin
            errors++;
            $display("FAIL final_flags: p=%b a=%b e=%b t=%b z=%b kind=%0d",
                     pronto, acertou, errou, timeout, zeraR, kind);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (db_estado !== 4'h0 || endereco !== '0 || rodada !== '0 ||
            zeraR !== 1'b1 || registraR || pronto || acertou ||
            errou || timeout) begin
            errors++;
            $display("FAIL reset: db=%h e=%0d r=%0d z=%b p=%b a=%b er=%b t=%b",
                     db_estado, endereco, rodada, zeraR, pronto,
                     acertou, errou, timeout);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (db_estado !== 4'h0) begin
            errors++;
            $display("FAIL idle: db=%h want 0", db_estado);
        end
    endtask

    task automatic test_win();
        play_game(0, 0, 0);
    endtask

    task automatic test_wrong();
        play_game(1, 2, 1);
    endtask

    task automatic test_timeout();
        play_game(2, 0, 0);
    endtask

    task automatic test_random();
        int k, fr, fm;
        for (int g = 0; g < 8; g++) begin
            k  = $urandom_range(0, 2);
            fr = $urandom_range(0, NR - 1);
            fm = $urandom_range(0, fr);
            play_game(k, fr, fm);
        end
    endtask

    task automatic test_boundary();
        bit ok;
        timeout_en = 1'b1;
        start_game();
        wait_state(4'h3, ok);
        repeat (TO - 1) tick();
        checks++;
        if (!ok || db_estado !== 4'h3) begin
            errors++;
            $display("FAIL boundary_pre: ok=%b db=%h want 3", ok, db_estado);
        end
        jogada = 1'b1;
        igual  = 1'b1;
        tick();
        jogada = 1'b0;
        checks++;
        if (db_estado !== 4'h4 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL boundary_race: db=%h t=%b want db=4 t=0",
                     db_estado, timeout);
        end
        tick();
        tick();
        igual = 1'b0;
        checks++;
        if (db_estado !== 4'h7) begin
            errors++;
            $display("FAIL boundary_next: db=%h want 7", db_estado);
        end
    endtask

    task automatic test_no_timeout();
        bit ok;
        wait_state(4'h3, ok);
        timeout_en = 1'b0;
        iniciar = 1'b1;
        repeat (100) tick();
        iniciar = 1'b0;
        checks++;
        if (!ok || db_estado !== 4'h3 || rodada !== AW'(1)) begin
            errors++;
            $display("FAIL no_timeout: db=%h r=%0d want db=3 r=1",
                     db_estado, rodada);
        end
        timeout_en = 1'b1;
        tick();
        checks++;
        if (db_estado !== 4'hA) begin
            errors++;
            $display("FAIL saturate: db=%h want A", db_estado);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        timeout_en = 1'b1;
        start_game();
        for (int r = 0; r < 2; r++) begin
            for (int m = 0; m <= r; m++) begin
                wait_state(4'h3, ok);
                do_move(1'b1);
            end
        end
        wait_state(4'h3, ok);
        jogada = 1'b1;
        igual  = 1'b1;
        tick();
        jogada = 1'b0;
        tick();
        checks++;
        if (!ok || db_estado !== 4'h5 || rodada !== AW'(2)) begin
            errors++;
            $display("FAIL mid_pre: db=%h r=%0d want db=5 r=2",
                     db_estado, rodada);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        igual = 1'b0;
        checks++;
        if (db_estado !== 4'h0 || endereco !== '0 || rodada !== '0 ||
            zeraR !== 1'b1 || pronto !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: db=%h e=%0d r=%0d z=%b p=%b",
                     db_estado, endereco, rodada, zeraR, pronto);
        end
    endtask

    task automatic test_restart();
        play_game(1, 1, 0);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        checks++;
        if (db_estado !== 4'h1 || errou !== 1'b0 || pronto !== 1'b0) begin
            errors++;
            $display("FAIL restart1: db=%h er=%b p=%b want db=1 er=0 p=0",
                     db_estado, errou, pronto);
        end
        tick();
        checks++;
        if (db_estado !== 4'h2 || rodada !== '0 || endereco !== '0) begin
            errors++;
            $display("FAIL restart2: db=%h r=%0d e=%0d want db=2 r=0 e=0",
                     db_estado, rodada, endereco);
        end
    endtask

    initial begin
        reset      = 1'b1;
        iniciar    = 1'b0;
        jogada     = 1'b0;
        igual      = 1'b0;
        timeout_en = 1'b1;
        test_reset();
        test_win();
        test_wrong();
        test_timeout();
        test_random();
        test_boundary();
        test_no_timeout();
        test_reset_mid();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle_rodadas.md
Name: unidade_controle_rodadas

Overview:
- Parametrised control unit for the sequence-memory game.
- Game runs in rounds: round r (0-based) requires r+1 correct moves, replayed from address 0.
- Unit owns the address and round counters and a per-move timeout timer.
- Drives the datapath: memory address, move register control. Datapath supplies the `igual` comparison result.

Parameters:
- ADDR_W, 4: width of address and round counters.
- N_RODADAS, 16: rounds needed to win; 1 <= N_RODADAS <= 2^ADDR_W.
- TIMEOUT, 5000: clock cycles allowed in `espera` before timeout; >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; forces `inicial` and clears all counters.
- iniciar  in  1  start/restart request.
- jogada  in  1  single-cycle pulse: a move is available.
- igual  in  1  datapath: registered move equals memory[endereco].
- timeout_en  in  1  1 = timeout active; 0 = wait indefinitely.
- endereco  out  ADDR_W  memory address / move index within round.
- rodada  out  ADDR_W  current round index.
- zeraR  out  1  clear move register.
- registraR  out  1  load move register.
- pronto  out  1  game finished (any final state).
- acertou  out  1  game won.
- errou  out  1  game lost (wrong move or timeout).
- timeout  out  1  loss caused by timeout.
- db_estado  out  4  state code for debug display.

Behaviour:
- Moore FSM; all outputs decode from the current state or registered counters. No combinational input-to-output paths.
- States (db_estado):
  - inicial 0
  - inicializa 1
  - inicio_rodada 2
  - espera 3
  - registra 4
  - compara 5
  - proxima 6
  - proxima_rodada 7
  - final_acerto 8
  - final_erro 9
  - final_timeout A
  - illegal code -> db_estado F; next state is inicial.
- Transitions:
  - inicial: iniciar -> inicializa, else stay.
  - inicializa -> inicio_rodada.
  - inicio_rodada -> espera.
  - espera:
    - jogada -> registra;
    - else if timeout_en and timer == TIMEOUT-1 -> final_timeout;
    - else stay.
  - registra -> compara.
  - compara:
    - !igual -> final_erro;
    - igual and endereco != rodada -> proxima;
    - igual and endereco == rodada and rodada == N_RODADAS-1 -> final_acerto;
    - igual and endereco == rodada, otherwise -> proxima_rodada.
  - proxima -> espera.
  - proxima_rodada -> inicio_rodada.
  - final_acerto / final_erro / final_timeout: iniciar -> inicializa, else stay.
- endereco:
  - <= 0 on edges where state is inicial, inicializa or inicio_rodada;
  - +1 on the edge in proxima;
  - holds otherwise.
- rodada:
  - <= 0 on edges in inicial or inicializa;
  - +1 on the edge in proxima_rodada;
  - holds otherwise.
- Counter values hold in final states, so the losing or winning round stays readable.
- Timer: internal, width = ceil(log2(TIMEOUT)).
  - Cleared on every edge where state != espera.
  - +1 on each espera edge without jogada.
  - Timeout fires after exactly TIMEOUT consecutive cycles in espera with jogada low.
  - When timeout_en = 0, the timer saturates at TIMEOUT-1 (no wrap).
- Output decode:
  - zeraR = inicial | inicializa.
  - registraR = registra.
  - pronto = any final state.
  - acertou = final_acerto.
  - errou = final_erro | final_timeout.
  - timeout = final_timeout.
- Reset values:
  - state inicial; endereco 0; rodada 0; timer 0.
  - zeraR 1; db_estado 0; every other output 0.
- Simultaneous events:
  - jogada on the timer's terminal cycle: jogada wins, go to registra.
  - iniciar is ignored outside inicial and the final states.
  - reset has priority over all inputs in every state, including mid-round.
- Latency per correct non-final move: jogada pulse -> registra -> compara -> proxima -> espera (3 cycles after the pulse edge).

Test Plan:
- Full win (N_RODADAS=4, TIMEOUT=8): iniciar, then 10 jogada pulses with igual=1 -> rodada steps 0..3; endereco returns to 0 at each inicio_rodada; after the 10th compare, pronto=1, acertou=1, db_estado=8, rodada=3, endereco=3.
- Wrong move: win rounds 0 and 1, then igual=0 on move endereco=1 of round 2 -> final_erro; errou=1, timeout=0, rodada=2, endereco=1, db_estado=9.
- Timeout (timeout_en=1, TIMEOUT=8): no jogada in espera -> exactly 8 cycles in db_estado=3, then final_timeout; errou=1, timeout=1, pronto=1, db_estado=A.
- Boundary race: jogada on the 8th espera cycle -> registra (db_estado=4), no timeout. With timeout_en=0, 100 idle cycles -> still espera.
- Reset mid-game: synchronous reset in round 2 during compara -> next edge state=inicial; endereco=0, rodada=0, zeraR=1, pronto=0.
- Restart from final: iniciar in final_erro -> inicializa then inicio_rodada; rodada=0, errou=0.
